dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001: Parameter WIDTH, default 32, data and address width in bits.
REQ-002: Parameter DEPTH, default 256, storage size in WIDTH-bit words.
REQ-003: Parameter LATENCY, default 2, wait cycles between request acceptance and memory access; legal range 0..7.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: req_valid  input  1  initiator presents a request.
REQ-007: req_ready  output  1  responder can accept a request this cycle.
REQ-008: req_we  input  1  1 = store, 0 = load.
REQ-009: req_addr  input  WIDTH  byte address.
REQ-010: req_wdata  input  WIDTH  store data.
REQ-011: req_be  input  WIDTH/8  store byte enables; bit i covers bits 8i+7..8i.
REQ-012: rsp_valid  output  1  response available.
REQ-013: rsp_ready  input  1  initiator accepts the response.
REQ-014: rsp_rdata  output  WIDTH  load data; 0 for stores and errors.
REQ-015: rsp_err  output  1  request was misaligned or out of range.
REQ-016: busy  output  1  high in any state other than IDLE.

Function
REQ-017: The state machine SHALL have three states: IDLE, WAIT and RESP.
REQ-018: req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-019: A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_be SHALL be latched on that edge.
REQ-020: On acceptance with LATENCY=0, the FSM SHALL go IDLE->RESP and perform the access on the same edge.
REQ-021: On acceptance with LATENCY>0, the FSM SHALL go IDLE->WAIT and load the wait counter with LATENCY-1.
REQ-022: In WAIT the counter SHALL decrement each cycle; on the edge where it equals 0, the access SHALL be performed and the FSM SHALL go to RESP.
REQ-023: rsp_valid SHALL therefore rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-024: Inputs on req_* after acceptance SHALL have no effect until the FSM returns to IDLE.
REQ-025: In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until a rising edge with rsp_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-026: No new request SHALL be accepted on the same edge as a response handshake; the earliest next acceptance is the following edge.
REQ-027: Word index = latched addr[WIDTH-1:2].
REQ-028: An error SHALL be flagged if addr[1:0]!=0 or word index >= DEPTH.
REQ-029: On error, storage SHALL be unchanged, rsp_rdata=0 and rsp_err=1.
REQ-030: A valid store SHALL update only the bytes whose req_be bit is 1.
REQ-031: A store with be=0 SHALL complete normally with rsp_err=0 and no change to storage.
REQ-032: A valid load SHALL return the full word, ignore be, and set rsp_err=0.
REQ-033: A store response SHALL carry rsp_rdata=0.
REQ-034: A load SHALL observe all stores whose responses completed earlier.
REQ-035: With rsp_ready held at 1, throughput SHALL be one request per LATENCY+2 cycles.

Reset
REQ-036: While rst=1 at a rising edge, the FSM SHALL go to IDLE and the wait counter SHALL be cleared.
REQ-037: While rst=1 at a rising edge, all storage words SHALL be cleared to 0.
REQ-038: While rst=1 at a rising edge, outputs SHALL take their reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-039: Reset in WAIT or RESP SHALL abandon the transaction: a pending store is not performed and no response is produced.
REQ-040: rst SHALL take priority over any simultaneous handshake.

Verification (LATENCY=2, DEPTH=256)
REQ-041: Store 0xDEADBEEF to 0x10 with be=0xF, then load 0x10 -> rsp_valid rises 3 cycles after each acceptance; load returns rdata=0xDEADBEEF, err=0.
REQ-042: Store 0x11223344 to 0x10 with be=0x5 over prior 0xDEADBEEF, then load 0x10 -> rdata=0xDE22BE44.
REQ-043: Load 0x13 (misaligned) and store to 0x400 (index 256) -> err=1, rdata=0 for both; a later load of 0x400-4 is unaffected.
REQ-044: Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable and req_ready=0 throughout; handshake on cycle 6 returns the FSM to IDLE.
REQ-045: Assert rst in WAIT during a store of 0xCAFEF00D to 0x20 -> no response is produced; a following load of 0x20 returns 0.
REQ-046: Back-to-back requests with rsp_ready=1 -> one acceptance every 4 cycles; rsp_valid is never high while req_ready is high.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator
// and the data-memory responder.
interface dmem_responder_if #(
   parameter int WIDTH = 32
);
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [WIDTH-1:0]   req_addr;
   logic [WIDTH-1:0]   req_wdata;
   logic [WIDTH/8-1:0] req_be;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [WIDTH-1:0]   rsp_rdata;
   logic               rsp_err;

   modport master (
      output req_valid, req_we, req_addr,
      output req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid,
      input  rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr,
      input  req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid,
      output rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed access latency,
// byte-enable stores and misalign/range error reporting.
module dmem_responder #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus,
   output logic             busy
);
   localparam int NB = WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] CNT_INIT =
      (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [WIDTH-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [NB-1:0]     be_q, be_d;
   logic [WIDTH-1:0]  rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic              acc;
   logic              wr_en;
   logic              a_we;
   logic [WIDTH-1:0]  a_addr;
   logic [WIDTH-1:0]  a_wdata;
   logic [NB-1:0]     a_be;
   logic [IW-1:0]     a_idx;
   logic              a_err;
   logic [WIDTH-1:0]  a_word;
   logic [WIDTH-1:0]  wr_word;

   // With zero latency the access uses the request still on the bus.
   always_comb begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_be    = be_q;
      if (state_q == IDLE) begin
         a_we    = bus.req_we;
         a_addr  = bus.req_addr;
         a_wdata = bus.req_wdata;
         a_be    = bus.req_be;
      end
      a_idx  = a_addr[IW+1:2];
      a_err  = (a_addr[1:0] != 2'b00) ||
               (a_addr[WIDTH-1:2] >= (WIDTH-2)'(DEPTH));
      a_word = mem_q[a_idx];
      wr_word = a_word;
      for (int i = 0; i < NB; i++) begin
         if (a_be[i]) wr_word[8*i +: 8] = a_wdata[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      acc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               if (LATENCY == 0) begin
                  acc     = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               acc     = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (acc) begin
         rdata_d = (a_err || a_we) ? '0 : a_word;
         err_d   = a_err;
      end
      wr_en = acc && a_we && !a_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[a_idx] <= wr_word;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vectors, corner sequences
// and random traffic against a word-array reference model.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem_m [256];

   dmem_responder_if #(.WIDTH(32)) bif ();

   dmem_responder #(
      .WIDTH(32),
      .DEPTH(256),
      .LATENCY(2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bif.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
   endtask

   task automatic model_access(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [3:0] be,
                               output logic [31:0] rd,
                               output logic er);
      int idx;
      idx = int'(addr >> 2);
      er  = (addr % 4 != 0) || (addr / 4 >= 256);
      rd  = 32'h0;
      if (!er) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            rd = mem_m[idx];
         end
      end
   endtask

   // Request lines carry junk while busy; they must not matter.
   task automatic do_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [3:0] be,
                         output logic [31:0] rd, output logic er,
                         output int cyc);
      bif.req_we    = we;
      bif.req_addr  = addr;
      bif.req_wdata = wdata;
      bif.req_be    = be;
      bif.req_valid = 1'b1;
      bif.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bif.req_we    = 1'($urandom);
      bif.req_addr  = $urandom;
      bif.req_wdata = $urandom;
      bif.req_be    = 4'($urandom);
      cyc = 1;
      while (!bif.rsp_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      rd = bif.rsp_rdata;
      er = bif.rsp_err;
      bif.req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd, exp_rd, r0;
      logic        er, exp_er, e0;
      int          cyc, viol, stable_bad;
      int          acc_c [$];

      vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
      vt[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0, 1'b0};
      vt[3]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDE22BE44, 1'b0};
      vt[4]  = '{1'b0, 32'h13,  32'h0,        4'hF, 32'h0, 1'b1};
      vt[5]  = '{1'b1, 32'h400, 32'hAAAAAAAA, 4'hF, 32'h0, 1'b1};
      vt[6]  = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h0, 1'b0};
      vt[7]  = '{1'b1, 32'h3FC, 32'h12345678, 4'h0, 32'h0, 1'b0};
      vt[8]  = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h0, 1'b0};
      vt[9]  = '{1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0, 1'b0};
      vt[10] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h12345678, 1'b0};
      vt[11] = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0, 1'b1};

      rst = 1'b1;
      bif.req_valid = 1'b0;
      bif.req_we    = 1'b0;
      bif.req_addr  = 32'h0;
      bif.req_wdata = 32'h0;
      bif.req_be    = 4'h0;
      bif.rsp_ready = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      chk("rst_rdata", bif.rsp_rdata, 32'h0);
      chk("rst_err", 32'(bif.rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be,
                rd, er, cyc);
         model_access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be,
                      exp_rd, exp_er);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
         chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd3);
      end

      // Response held off by the initiator for five cycles.
      do_req(1'b1, 32'h10, 32'h5A5AA5A5, 4'hF, rd, er, cyc);
      model_access(1'b1, 32'h10, 32'h5A5AA5A5, 4'hF, exp_rd, exp_er);
      bif.req_we    = 1'b0;
      bif.req_addr  = 32'h10;
      bif.req_valid = 1'b1;
      bif.rsp_ready = 1'b0;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      cyc = 1;
      while (!bif.rsp_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("stall_latency", 32'(cyc), 32'd3);
      r0 = bif.rsp_rdata;
      e0 = bif.rsp_err;
      chk("stall_rdata", r0, 32'h5A5AA5A5);
      chk("stall_err", 32'(e0), 32'd0);
      bif.req_valid = 1'b1;
      stable_bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (!bif.rsp_valid || bif.rsp_rdata !== r0 ||
             bif.rsp_err !== e0 || bif.req_ready)
            stable_bad++;
      end
      chk("stall_stable", 32'(stable_bad), 32'd0);
      bif.req_valid = 1'b0;
      bif.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_ready", 32'(bif.req_ready), 32'd1);
      chk("stall_release_valid", 32'(bif.rsp_valid), 32'd0);

      // Reset while a store waits: store dropped, memory cleared.
      bif.req_we    = 1'b1;
      bif.req_addr  = 32'h20;
      bif.req_wdata = 32'hCAFEF00D;
      bif.req_be    = 4'hF;
      bif.req_valid = 1'b1;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      chk("wait_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      chk("wrst_req_ready", 32'(bif.req_ready), 32'd1);
      chk("wrst_busy", 32'(busy), 32'd0);
      viol = 0;
      for (int k = 0; k < 5; k++) begin
         if (bif.rsp_valid) viol++;
         @(posedge clk); #1;
      end
      chk("wrst_no_rsp", 32'(viol), 32'd0);
      do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, cyc);
      chk("wrst_load_rdata", rd, 32'h0);
      chk("wrst_load_err", 32'(er), 32'd0);

      // Back-to-back loads with the response always accepted.
      bif.req_we    = 1'b0;
      bif.req_valid = 1'b1;
      bif.rsp_ready = 1'b1;
      viol = 0;
      for (int c = 0; c < 24; c++) begin
         bif.req_addr = 32'($urandom_range(0, 255)) << 2;
         if (bif.req_ready && bif.rsp_valid) viol++;
         if (bif.req_ready) acc_c.push_back(c);
         @(posedge clk); #1;
      end
      bif.req_valid = 1'b0;
      chk("b2b_overlap", 32'(viol), 32'd0);
      chk("b2b_count", 32'(acc_c.size()), 32'd6);
      for (int i = 1; i < acc_c.size(); i++)
         chk($sformatf("b2b_gap%0d", i),
             32'(acc_c[i] - acc_c[i-1]), 32'd4);
      cyc = 0;
      while (busy && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b_drain", 32'(busy), 32'd0);

      // Random traffic against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic        we;
         logic [31:0] addr, wdata;
         logic [3:0]  be;
         int          sel;
         sel   = int'($urandom_range(0, 7));
         we    = 1'($urandom);
         wdata = $urandom;
         be    = 4'($urandom);
         addr  = 32'($urandom_range(0, 15)) << 2;
         if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
         if (sel == 1) addr = 32'h400 + (32'($urandom_range(0, 63)) << 2);
         do_req(we, addr, wdata, be, rd, er, cyc);
         model_access(we, addr, wdata, be, exp_rd, exp_er);
         chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
         chk($sformatf("rnd%0d_err", n), 32'(er), 32'(exp_er));
         chk($sformatf("rnd%0d_latency", n), 32'(cyc), 32'd3);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
